pll_loop_filter_pi_v2: RTL and testbench

Parametrised second-generation digital PI loop filter for the DPLL. It sits between the phase detector and the VCO model. It turns a signed multi-bit phase error into an unsigned VCO control code, and adds the following over the first-generation filter:
- integrator anti-windup clamping
- a moving-average smoothed output
- track/hold/manual modes
- a lock detector
The legacy single-bit dir input maps to phase_err = +1/-1 with err_valid tied high.

---
 rtl/pll_loop_filter_pi_v2.sv | 120 ++++++++++++
 tb/tb_pll_loop_filter_pi_v2.sv | 135 +++++++++++++
 2 files changed

// File: rtl/pll_loop_filter_pi_v2.sv
// pll_loop_filter_pi_v2: PI loop filter with anti-windup, smoothing, track/hold/manual modes and lock detect.
module pll_loop_filter_pi_v2 #(
    parameter int CTRL_WIDTH  = 12,
    parameter int ERR_WIDTH   = 4,
    parameter int P_GAIN      = 20,
    parameter int I_GAIN      = 1,
    parameter int CTRL_INIT   = 2048,
    parameter int SMOOTH_LOG2 = 3,
    parameter int LOCK_THRESH = 2,
    parameter int LOCK_COUNT  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  err_valid,
    input  logic [ERR_WIDTH-1:0]  phase_err,
    input  logic [1:0]            mode,
    input  logic [CTRL_WIDTH-1:0] manual_code,
    output logic [CTRL_WIDTH-1:0] ctrl_code,
    output logic [CTRL_WIDTH-1:0] ctrl_code_smoothed,
    output logic                  ctrl_valid,
    output logic                  locked,
    output logic                  sat_hi,
    output logic                  sat_lo
);
    localparam int W  = CTRL_WIDTH + ERR_WIDTH + 16;
    localparam int N  = 1 << SMOOTH_LOG2;
    localparam int SW = CTRL_WIDTH + SMOOTH_LOG2;
    localparam int CW = $clog2(LOCK_COUNT + 1);
    localparam logic signed [W-1:0] MAX = {{(W-CTRL_WIDTH){1'b0}}, {CTRL_WIDTH{1'b1}}};
    localparam logic signed [W-1:0] IG = W'(I_GAIN);
    localparam logic signed [W-1:0] PG = W'(P_GAIN);
    localparam logic signed [W-1:0] LT = W'(LOCK_THRESH);
    localparam logic [CTRL_WIDTH-1:0] CINIT = CTRL_WIDTH'(CTRL_INIT);
    localparam logic [SW-1:0] SUM_INIT = SW'(CTRL_INIT) << SMOOTH_LOG2;
    localparam logic [CW-1:0] LCNT = CW'(LOCK_COUNT);

    logic [CTRL_WIDTH-1:0] integ_q, integ_d, ctrl_q, ctrl_d, smooth_q, ctrl_t;
    logic [CTRL_WIDTH-1:0] hist_q [N];
    logic [SW-1:0]         sum_q, sum_d;
    logic [SMOOTH_LOG2-1:0] ptr_q;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  valid_q, valid_d, locked_q, hi_q, hi_d, lo_q, lo_d;
    logic signed [W-1:0]   err_s, integ_s, i_sum, i_next, raw, err_abs;
    logic                  raw_hi, raw_lo, in_win;

    assign err_s   = {{(W-ERR_WIDTH){phase_err[ERR_WIDTH-1]}}, phase_err};
    assign integ_s = {{(W-CTRL_WIDTH){1'b0}}, integ_q};
    assign i_sum   = integ_s + IG * err_s;
    // integrator is clamped before the proportional term is added (anti-windup)
    assign i_next  = i_sum[W-1] ? '0 : (i_sum > MAX ? MAX : i_sum);
    assign raw     = i_next + PG * err_s;
    assign raw_lo  = raw[W-1];
    assign raw_hi  = !raw[W-1] && raw > MAX;
    assign ctrl_t  = raw_hi ? {CTRL_WIDTH{1'b1}} : (raw_lo ? '0 : raw[CTRL_WIDTH-1:0]);
    assign err_abs = err_s[W-1] ? -err_s : err_s;
    assign in_win  = err_abs <= LT;

    always_comb begin
        integ_d = integ_q;
        ctrl_d  = ctrl_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        if (mode == 2'b10) begin
            integ_d = manual_code;
            ctrl_d  = manual_code;
            hi_d    = 1'b0;
            lo_d    = 1'b0;
            cnt_d   = '0;
            valid_d = 1'b1;
        end else if (mode == 2'b00 && err_valid) begin
            integ_d = i_next[CTRL_WIDTH-1:0];
            ctrl_d  = ctrl_t;
            hi_d    = raw_hi;
            lo_d    = raw_lo;
            cnt_d   = in_win ? (cnt_q == LCNT ? cnt_q : cnt_q + 1'b1) : '0;
            valid_d = 1'b1;
        end
    end

    assign sum_d = valid_q ? sum_q + SW'(ctrl_q) - SW'(hist_q[ptr_q]) : sum_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            integ_q  <= CINIT;
            ctrl_q   <= CINIT;
            smooth_q <= CINIT;
            sum_q    <= SUM_INIT;
            ptr_q    <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
            hi_q     <= 1'b0;
            lo_q     <= 1'b0;
            for (int k = 0; k < N; k++) hist_q[k] <= CINIT;
        end else begin
            integ_q  <= integ_d;
            ctrl_q   <= ctrl_d;
            smooth_q <= sum_d[SW-1:SMOOTH_LOG2];
            sum_q    <= sum_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            locked_q <= cnt_d == LCNT;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            if (valid_q) begin
                hist_q[ptr_q] <= ctrl_q;
                ptr_q         <= ptr_q + 1'b1;
            end
        end
    end

    assign ctrl_code          = ctrl_q;
    assign ctrl_code_smoothed = smooth_q;
    assign ctrl_valid         = valid_q;
    assign locked             = locked_q;
    assign sat_hi             = hi_q;
    assign sat_lo             = lo_q;
endmodule

// File: tb/tb_pll_loop_filter_pi_v2.sv
// tb_pll_loop_filter_pi_v2: directed vector table plus hand sequences for the PI loop filter.
module tb_pll_loop_filter_pi_v2;
    logic        clk = 1'b0;
    logic        rst, err_valid;
    logic [3:0]  phase_err;
    logic [1:0]  mode;
    logic [11:0] manual_code, ctrl_code, ctrl_code_smoothed;
    logic        ctrl_valid, locked, sat_hi, sat_lo;
    int          n_tests = 0;
    int          n_fail = 0;

    pll_loop_filter_pi_v2 dut (
        .clk(clk), .rst(rst), .err_valid(err_valid), .phase_err(phase_err),
        .mode(mode), .manual_code(manual_code), .ctrl_code(ctrl_code),
        .ctrl_code_smoothed(ctrl_code_smoothed), .ctrl_valid(ctrl_valid),
        .locked(locked), .sat_hi(sat_hi), .sat_lo(sat_lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic        ev;
        logic [3:0]  err;
        logic [11:0] man;
        logic [11:0] ctrl;
        logic        v, hi, lo, lk;
    } vec_t;
    vec_t tv [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input logic [1:0] m, input logic ev, input logic [3:0] e, input logic [11:0] mc);
        mode = m; err_valid = ev; phase_err = e; manual_code = mc;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_ctrl"}, 32'(ctrl_code), 2048);
        chk({nm, "_smooth"}, 32'(ctrl_code_smoothed), 2048);
        chk({nm, "_valid"}, 32'(ctrl_valid), 0);
        chk({nm, "_locked"}, 32'(locked), 0);
        chk({nm, "_sat"}, {30'd0, sat_hi, sat_lo}, 0);
    endtask

    initial begin
        tv[0]  = '{2'b00, 1'b0, 4'd3,  12'd0,    12'd2048, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[1]  = '{2'b00, 1'b1, 4'd1,  12'd0,    12'd2069, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[2]  = '{2'b00, 1'b1, 4'd0,  12'd0,    12'd2049, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[3]  = '{2'b01, 1'b1, 4'd7,  12'd0,    12'd2049, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[4]  = '{2'b11, 1'b1, 4'b1001, 12'd0,  12'd2049, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[5]  = '{2'b00, 1'b1, 4'b1000, 12'd0,  12'd1881, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[6]  = '{2'b10, 1'b0, 4'd0,  12'd0,    12'd0,    1'b1, 1'b0, 1'b0, 1'b0};
        tv[7]  = '{2'b00, 1'b1, 4'b1111, 12'd0,  12'd0,    1'b1, 1'b0, 1'b1, 1'b0};
        tv[8]  = '{2'b00, 1'b1, 4'd0,  12'd0,    12'd0,    1'b1, 1'b0, 1'b0, 1'b0};
        tv[9]  = '{2'b10, 1'b1, 4'd7,  12'd4095, 12'd4095, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[10] = '{2'b00, 1'b1, 4'd1,  12'd0,    12'd4095, 1'b1, 1'b1, 1'b0, 1'b0};
        tv[11] = '{2'b00, 1'b0, 4'd5,  12'd0,    12'd4095, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[12] = '{2'b01, 1'b1, 4'b1101, 12'd0,  12'd4095, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[13] = '{2'b00, 1'b1, 4'b1111, 12'd0,  12'd4074, 1'b1, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; mode = 2'b00; err_valid = 1'b0; phase_err = '0; manual_code = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset");
        rst = 1'b0;
        repeat (5) step(2'b00, 1'b0, 4'd0, 12'd0);
        chk_reset("idle");

        step(2'b00, 1'b1, 4'd1, 12'd0);
        chk("step_ctrl", 32'(ctrl_code), 2069);
        chk("step_valid", 32'(ctrl_valid), 1);
        chk("step_smooth_lag", 32'(ctrl_code_smoothed), 2048);
        step(2'b00, 1'b1, 4'd0, 12'd0);
        chk("step_zero_ctrl", 32'(ctrl_code), 2049);
        chk("step_smooth", 32'(ctrl_code_smoothed), 2050);

        repeat (300) step(2'b00, 1'b1, 4'd7, 12'd0);
        chk("sat_ctrl", 32'(ctrl_code), 4095);
        chk("sat_hi", 32'(sat_hi), 1);
        step(2'b00, 1'b1, 4'b1001, 12'd0);
        chk("unwind_ctrl", 32'(ctrl_code), 3948);
        chk("unwind_hi", 32'(sat_hi), 0);

        for (int i = 0; i < 63; i++) step(2'b00, 1'b1, i[0] ? 4'b1111 : 4'd1, 12'd0);
        chk("lock_63", 32'(locked), 0);
        step(2'b00, 1'b1, 4'b1111, 12'd0);
        chk("lock_64", 32'(locked), 1);
        step(2'b00, 1'b1, 4'd5, 12'd0);
        chk("lock_drop", 32'(locked), 0);
        for (int i = 0; i < 63; i++) step(2'b00, 1'b1, i[0] ? 4'b1110 : 4'd2, 12'd0);
        chk("relock_63", 32'(locked), 0);
        step(2'b00, 1'b1, 4'b1110, 12'd0);
        chk("relock_64", 32'(locked), 1);
        step(2'b01, 1'b1, 4'd7, 12'd0);
        chk("hold_locked", 32'(locked), 1);
        step(2'b00, 1'b1, 4'd3, 12'd0);
        chk("thresh_drop", 32'(locked), 0);

        step(2'b10, 1'b0, 4'd0, 12'd1000);
        chk("man_ctrl", 32'(ctrl_code), 1000);
        chk("man_locked", 32'(locked), 0);
        chk("man_valid", 32'(ctrl_valid), 1);
        repeat (8) step(2'b10, 1'b0, 4'd0, 12'd1000);
        chk("man_smooth", 32'(ctrl_code_smoothed), 1000);
        step(2'b00, 1'b1, 4'd0, 12'd0);
        chk("bumpless", 32'(ctrl_code), 1000);

        step(2'b01, 1'b1, 4'd7, 12'd0);
        chk("hold_ctrl", 32'(ctrl_code), 1000);
        chk("hold_valid", 32'(ctrl_valid), 0);
        repeat (3) step(2'b00, 1'b1, 4'd7, 12'd0);
        rst = 1'b1;
        step(2'b00, 1'b1, 4'd7, 12'd0);
        chk_reset("midrst");
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            step(tv[i].mode, tv[i].ev, tv[i].err, tv[i].man);
            chk($sformatf("vec%0d_ctrl", i), 32'(ctrl_code), 32'(tv[i].ctrl));
            chk($sformatf("vec%0d_flags", i), {28'd0, ctrl_valid, sat_hi, sat_lo, locked},
                {28'd0, tv[i].v, tv[i].hi, tv[i].lo, tv[i].lk});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
